// File: rtl/ps2_pkg.sv
// Shared scan-code constants, decoder state encoding and key event record
// for the PS/2 key event path.
package ps2_pkg;

    localparam logic [7:0] PFX_EXT    = 8'hE0;
    localparam logic [7:0] PFX_BRK    = 8'hF0;
    localparam logic [7:0] PFX_PAUSE  = 8'hE1;
    localparam logic [7:0] BAT_OK     = 8'hAA;
    localparam logic [7:0] LSHIFT     = 8'h12;
    localparam logic [7:0] RSHIFT     = 8'h59;
    localparam logic [7:0] CTRL       = 8'h14;
    localparam logic [7:0] ALT        = 8'h11;
    localparam logic [7:0] CAPS       = 8'h58;
    localparam logic [7:0] FAKE_SHIFT = 8'h12;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_EXT    = 3'd1,
        ST_BRK    = 3'd2,
        ST_EXTBRK = 3'd3,
        ST_PAUSE  = 3'd4
    } decState_t;

    // Event record: {caps, alt, ctrl, shift}, extended flag, break flag, code.
    typedef struct packed {
        logic [3:0] mods;
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } keyEvent_t;

    localparam int EVT_W = $bits(keyEvent_t);

    // Keyboard housekeeping bytes (ack, echo, resend, error) that carry no key.
    function automatic logic isFiller(input logic [7:0] b);
        return (b == 8'h00) || (b == 8'hFF) || (b == 8'hFA) ||
               (b == 8'hEE) || (b == 8'hFE);
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Generic synchronous FIFO with a registered head: the head word and its
// valid flag are flops, so a push into an empty FIFO shows up one cycle later.
module ps2_event_fifo #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] popData,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtrReg, rdPtrReg, rdPtrNext;
    logic [AW:0]      countReg, countNext;
    logic [WIDTH-1:0] headReg, headNext;
    logic             validReg;
    logic             doPush, doPop;

    assign full    = (countReg == (AW+1)'(DEPTH));
    assign empty   = !validReg;
    assign popData = headReg;
    assign doPop   = pop && validReg;
    assign doPush  = push && (!full || doPop);

    // Next pointers/count and the word that becomes the head after this edge;
    // a write landing on the new head slot is forwarded directly.
    always_comb begin
        rdPtrNext = rdPtrReg + AW'(doPop);
        countNext = countReg + (AW+1)'(doPush) - (AW+1)'(doPop);
        headNext  = (doPush && (wrPtrReg == rdPtrNext)) ? pushData : mem[rdPtrNext];
    end

    // Storage array write port (no reset so it maps onto RAM).
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtrReg] <= pushData;
        end
    end

    // Pointers, occupancy and registered head.
    always_ff @(posedge clk) begin
        if (srst) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
            countReg <= '0;
            headReg  <= '0;
            validReg <= 1'b0;
        end else begin
            wrPtrReg <= wrPtrReg + AW'(doPush);
            rdPtrReg <= rdPtrNext;
            countReg <= countNext;
            headReg  <= headNext;
            validReg <= (countNext != '0);
        end
    end

endmodule

// File: rtl/ps2_keyevent_module.sv
// Turns the scan-code-set-2 byte stream into buffered key events with a
// modifier snapshot. Decoded events are registered once, then pushed into
// the event FIFO on the following edge.
module ps2_keyevent_module
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int PAUSE_LEN  = 7
) (
    input  logic       CLOCK,
    input  logic       RST,
    input  logic       iTrig,
    input  logic [7:0] iData,
    output logic       oValid,
    input  logic       iReady,
    output logic [7:0] oCode,
    output logic       oExt,
    output logic       oBreak,
    output logic [3:0] oMods,
    output logic       oOverflow
);

    localparam int PCW = $clog2(PAUSE_LEN + 1);

    decState_t      stateReg, stateNext;
    logic [PCW-1:0] pauseCntReg, pauseCntNext;
    logic           pauseLast;

    logic           evtFire, evtExt, evtBrk, batClear;
    logic [7:0]     evtCode;

    logic lshiftReg, rshiftReg, lctrlReg, rctrlReg, laltReg, raltReg, capsReg, capsHeldReg;
    logic lshiftNext, rshiftNext, lctrlNext, rctrlNext, laltNext, raltNext, capsNext, capsHeldNext;

    keyEvent_t      evtReg, evtNext;
    logic           evtValidReg;
    logic           overflowReg;

    logic           fifoPush, fifoPop, fifoFull, fifoEmpty;
    logic [EVT_W-1:0] headBits;
    keyEvent_t      headEvt;

    assign pauseLast = (pauseCntReg == PCW'(1));

    // Decoder state register.
    always_ff @(posedge CLOCK) begin
        if (RST) begin
            stateReg    <= ST_IDLE;
            pauseCntReg <= '0;
        end else begin
            stateReg    <= stateNext;
            pauseCntReg <= pauseCntNext;
        end
    end

    // Prefix folding: which state the next byte is interpreted in.
    always_comb begin
        stateNext    = stateReg;
        pauseCntNext = pauseCntReg;
        if (iTrig) begin
            case (stateReg)
                ST_IDLE: begin
                    if (iData == PFX_BRK) begin
                        stateNext = ST_BRK;
                    end else if (iData == PFX_EXT) begin
                        stateNext = ST_EXT;
                    end else if (iData == PFX_PAUSE) begin
                        stateNext    = ST_PAUSE;
                        pauseCntNext = PCW'(PAUSE_LEN);
                    end
                end
                ST_EXT:    stateNext = (iData == PFX_BRK) ? ST_EXTBRK : ST_IDLE;
                ST_BRK:    stateNext = ST_IDLE;
                ST_EXTBRK: stateNext = ST_IDLE;
                ST_PAUSE: begin
                    pauseCntNext = pauseCntReg - PCW'(1);
                    if (pauseLast) begin
                        stateNext = ST_IDLE;
                    end
                end
                default:   stateNext = ST_IDLE;
            endcase
        end
    end

    // Event generation for the byte arriving in the current state.
    always_comb begin
        evtFire  = 1'b0;
        evtExt   = 1'b0;
        evtBrk   = 1'b0;
        evtCode  = iData;
        batClear = 1'b0;
        if (iTrig) begin
            case (stateReg)
                ST_IDLE: begin
                    if (iData == BAT_OK) begin
                        batClear = 1'b1;
                    end else if (iData != PFX_BRK && iData != PFX_EXT &&
                                 iData != PFX_PAUSE && !isFiller(iData)) begin
                        evtFire = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (iData != PFX_BRK && iData != FAKE_SHIFT) begin
                        evtFire = 1'b1;
                        evtExt  = 1'b1;
                    end
                end
                ST_BRK: begin
                    evtFire = 1'b1;
                    evtBrk  = 1'b1;
                end
                ST_EXTBRK: begin
                    if (iData != FAKE_SHIFT) begin
                        evtFire = 1'b1;
                        evtExt  = 1'b1;
                        evtBrk  = 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (pauseLast) begin
                        evtFire = 1'b1;
                        evtExt  = 1'b1;
                        evtCode = PFX_PAUSE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Modifier tracking; caps_held stops typematic repeats from re-toggling.
    always_comb begin
        lshiftNext   = lshiftReg;
        rshiftNext   = rshiftReg;
        lctrlNext    = lctrlReg;
        rctrlNext    = rctrlReg;
        laltNext     = laltReg;
        raltNext     = raltReg;
        capsNext     = capsReg;
        capsHeldNext = capsHeldReg;
        if (batClear) begin
            lshiftNext   = 1'b0;
            rshiftNext   = 1'b0;
            lctrlNext    = 1'b0;
            rctrlNext    = 1'b0;
            laltNext     = 1'b0;
            raltNext     = 1'b0;
            capsNext     = 1'b0;
            capsHeldNext = 1'b0;
        end else if (evtFire) begin
            if (!evtExt && evtCode == LSHIFT) lshiftNext = !evtBrk;
            if (!evtExt && evtCode == RSHIFT) rshiftNext = !evtBrk;
            if (evtCode == CTRL) begin
                if (evtExt) rctrlNext = !evtBrk;
                else        lctrlNext = !evtBrk;
            end
            if (evtCode == ALT) begin
                if (evtExt) raltNext = !evtBrk;
                else        laltNext = !evtBrk;
            end
            if (!evtExt && evtCode == CAPS) begin
                if (evtBrk) begin
                    capsHeldNext = 1'b0;
                end else begin
                    if (!capsHeldReg) capsNext = !capsReg;
                    capsHeldNext = 1'b1;
                end
            end
        end
        evtNext.mods = {capsNext, laltNext | raltNext, lctrlNext | rctrlNext, lshiftNext | rshiftNext};
        evtNext.ext  = evtExt;
        evtNext.brk  = evtBrk;
        evtNext.code = evtCode;
    end

    // Modifier flags, the staged event and the overflow pulse.
    always_ff @(posedge CLOCK) begin
        if (RST) begin
            lshiftReg   <= 1'b0;
            rshiftReg   <= 1'b0;
            lctrlReg    <= 1'b0;
            rctrlReg    <= 1'b0;
            laltReg     <= 1'b0;
            raltReg     <= 1'b0;
            capsReg     <= 1'b0;
            capsHeldReg <= 1'b0;
            evtReg      <= '0;
            evtValidReg <= 1'b0;
            overflowReg <= 1'b0;
        end else begin
            lshiftReg   <= lshiftNext;
            rshiftReg   <= rshiftNext;
            lctrlReg    <= lctrlNext;
            rctrlReg    <= rctrlNext;
            laltReg     <= laltNext;
            raltReg     <= raltNext;
            capsReg     <= capsNext;
            capsHeldReg <= capsHeldNext;
            evtReg      <= evtNext;
            evtValidReg <= evtFire;
            overflowReg <= evtValidReg && fifoFull && !fifoPop;
        end
    end

    assign fifoPop  = !fifoEmpty && iReady;
    assign fifoPush = evtValidReg && (!fifoFull || fifoPop);

    ps2_event_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (CLOCK),
        .srst     (RST),
        .push     (fifoPush),
        .pushData (evtReg),
        .pop      (fifoPop),
        .popData  (headBits),
        .full     (fifoFull),
        .empty    (fifoEmpty)
    );

    assign headEvt   = keyEvent_t'(headBits);
    assign oValid    = !fifoEmpty;
    assign oCode     = headEvt.code;
    assign oExt      = headEvt.ext;
    assign oBreak    = headEvt.brk;
    assign oMods     = headEvt.mods;
    assign oOverflow = overflowReg;

endmodule

// File: tb/tb_ps2_keyevent_module.sv
// Directed bench for ps2_keyevent_module: a key-down-table model predicts
// the event queue every cycle, and literal expectations pin each scenario.
module tb_ps2_keyevent_module;

    localparam int FIFO_DEPTH = 4;
    localparam int PAUSE_LEN  = 7;

    logic       CLOCK = 1'b0;
    logic       RST = 1'b1;
    logic       iTrig = 1'b0;
    logic [7:0] iData = 8'h00;
    logic       iReady = 1'b1;
    logic       oValid, oExt, oBreak, oOverflow;
    logic [7:0] oCode;
    logic [3:0] oMods;

    always #5 CLOCK = ~CLOCK;

    ps2_keyevent_module #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .PAUSE_LEN  (PAUSE_LEN)
    ) dut (
        .CLOCK     (CLOCK),
        .RST       (RST),
        .iTrig     (iTrig),
        .iData     (iData),
        .oValid    (oValid),
        .iReady    (iReady),
        .oCode     (oCode),
        .oExt      (oExt),
        .oBreak    (oBreak),
        .oMods     (oMods),
        .oOverflow (oOverflow)
    );

    int checks = 0;
    int errors = 0;
    int ovfSeen = 0;
    int cycle = 0;
    bit compareEn = 1'b0;

    // Model state: queue of visible events, one staged event, prefix flags,
    // a table of keys currently held down and the caps lock latch.
    logic [13:0] q[$];
    logic [13:0] logQ[$];
    logic [13:0] pendEvt;
    bit          pendV = 1'b0;
    bit          ovfExp = 1'b0;
    bit          mExt = 1'b0;
    bit          mBrk = 1'b0;
    int          pauseLeft = 0;
    bit          pressed [0:511];
    bit          capsOn = 1'b0;

    function automatic logic [13:0] mk(input logic [3:0] m, input logic e, input logic b, input logic [7:0] c);
        return {m, e, b, c};
    endfunction

    task automatic clearKeys();
        for (int i = 0; i < 512; i++) pressed[i] = 1'b0;
        capsOn = 1'b0;
    endtask

    task automatic emit(input logic [7:0] c, input bit e, input bit b);
        int idx;
        logic [3:0] m;
        idx = e ? 256 + int'(c) : int'(c);
        if (idx == 'h058 && !b && !pressed[idx]) capsOn = !capsOn;
        pressed[idx] = !b;
        m = {capsOn,
             pressed['h011] | pressed['h111],
             pressed['h014] | pressed['h114],
             pressed['h012] | pressed['h059]};
        pendEvt = {m, e, b, c};
        pendV = 1'b1;
    endtask

    task automatic modelByte(input logic [7:0] b);
        if (pauseLeft > 0) begin
            pauseLeft--;
            if (pauseLeft == 0) emit(8'hE1, 1'b1, 1'b0);
        end else if (mBrk) begin
            if (!(mExt && b == 8'h12)) emit(b, mExt, 1'b1);
            mExt = 1'b0;
            mBrk = 1'b0;
        end else if (mExt) begin
            if (b == 8'hF0) begin
                mBrk = 1'b1;
            end else begin
                if (b != 8'h12) emit(b, 1'b1, 1'b0);
                mExt = 1'b0;
            end
        end else begin
            case (b)
                8'hF0: mBrk = 1'b1;
                8'hE0: mExt = 1'b1;
                8'hE1: pauseLeft = PAUSE_LEN;
                8'hAA: clearKeys();
                8'h00, 8'hFF, 8'hFA, 8'hEE, 8'hFE: ;
                default: emit(b, 1'b0, 1'b0);
            endcase
        end
    endtask

    // Model advance, transaction log and cycle counter on the active edge.
    always @(posedge CLOCK) begin
        cycle++;
        if (!RST && oValid && iReady) begin
            logQ.push_back({oMods, oExt, oBreak, oCode});
            $display("cycle %0d event code=%h ext=%b brk=%b mods=%b", cycle, oCode, oExt, oBreak, oMods);
        end
        if (RST) begin
            q.delete();
            pendV = 1'b0;
            ovfExp = 1'b0;
            mExt = 1'b0;
            mBrk = 1'b0;
            pauseLeft = 0;
            clearKeys();
        end else begin
            if (q.size() > 0 && iReady) void'(q.pop_front());
            ovfExp = 1'b0;
            if (pendV) begin
                if (q.size() < FIFO_DEPTH) q.push_back(pendEvt);
                else ovfExp = 1'b1;
            end
            pendV = 1'b0;
            if (iTrig) modelByte(iData);
        end
    end

    // Per-cycle comparison of the DUT head and overflow against the model.
    always @(negedge CLOCK) begin
        logic        expV;
        logic [13:0] expH;
        if (compareEn) begin
            checks++;
            expV = (q.size() != 0);
            expH = expV ? q[0] : 14'h0;
            if (oValid !== expV || oOverflow !== ovfExp ||
                (expV && {oMods, oExt, oBreak, oCode} !== expH)) begin
                errors++;
                $display("FAIL model cycle %0d: valid/ovf/head got %b/%b/%h expected %b/%b/%h",
                         cycle, oValid, oOverflow, {oMods, oExt, oBreak, oCode}, expV, ovfExp, expH);
            end
            if (oOverflow === 1'b1) ovfSeen++;
        end
    end

    task automatic checkLit(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic checkEvt(input string name, input int idx, input logic [13:0] exp);
        logic [13:0] got;
        got = (idx < logQ.size()) ? logQ[idx] : 14'bx;
        checkLit(name, {18'h0, got}, {18'h0, exp});
    endtask

    task automatic sendByte(input logic [7:0] b);
        @(negedge CLOCK);
        iTrig = 1'b1;
        iData = b;
        @(negedge CLOCK);
        iTrig = 1'b0;
    endtask

    // Sends n bytes packed MSB-first into v.
    task automatic sendSeq(input logic [63:0] v, input int n);
        logic [63:0] t;
        t = v;
        for (int i = 0; i < n; i++) sendByte(t[8*(n-1-i) +: 8]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLOCK);
    endtask

    initial begin
        clearKeys();
        RST = 1'b1;
        idle(3);
        checkLit("reset outputs", {17'h0, oValid, oCode, oExt, oBreak, oMods, oOverflow}, 32'h0);
        RST = 1'b0;
        compareEn = 1'b1;

        // Plain make and break
        sendSeq(64'h1C_F0_1C, 3);
        idle(6);
        checkLit("basic count", logQ.size(), 2);
        checkEvt("basic make", 0, mk(4'h0, 0, 0, 8'h1C));
        checkEvt("basic break", 1, mk(4'h0, 0, 1, 8'h1C));
        logQ.delete();

        // Shift held around a key, then extended make/break
        sendSeq(64'h12_1C_F0_1C_F0_12, 6);
        sendSeq(64'hE0_75_E0_F0_75, 5);
        idle(6);
        checkEvt("shift make", 0, mk(4'h1, 0, 0, 8'h12));
        checkEvt("shifted make", 1, mk(4'h1, 0, 0, 8'h1C));
        checkEvt("shifted break", 2, mk(4'h1, 0, 1, 8'h1C));
        checkEvt("shift break", 3, mk(4'h0, 0, 1, 8'h12));
        checkEvt("ext make", 4, mk(4'h0, 1, 0, 8'h75));
        checkEvt("ext break", 5, mk(4'h0, 1, 1, 8'h75));
        logQ.delete();

        // Caps typematic, then ctrl/alt combinations
        sendSeq(64'h58_58_58_F0_58_58, 6);
        sendSeq(64'hE0_14_11_F0_11_E0_F0_14, 8);
        idle(6);
        checkEvt("caps first", 0, mk(4'h8, 0, 0, 8'h58));
        checkEvt("caps repeat", 2, mk(4'h8, 0, 0, 8'h58));
        checkEvt("caps break", 3, mk(4'h8, 0, 1, 8'h58));
        checkEvt("caps retoggle", 4, mk(4'h0, 0, 0, 8'h58));
        checkEvt("rctrl make", 5, mk(4'h2, 1, 0, 8'h14));
        checkEvt("lalt with ctrl", 6, mk(4'h6, 0, 0, 8'h11));
        checkEvt("lalt break", 7, mk(4'h2, 0, 1, 8'h11));
        checkEvt("rctrl break", 8, mk(4'h0, 1, 1, 8'h14));
        logQ.delete();

        // Pause sequence, fake shift, BAT clear and filler bytes
        sendSeq(64'hE1_14_77_E1_F0_14_F0_77, 8);
        sendSeq(64'hE0_12_E0_7C, 4);
        sendSeq(64'h12_AA_FA_1C, 4);
        idle(6);
        checkLit("swallow count", logQ.size(), 4);
        checkEvt("pause event", 0, mk(4'h0, 1, 0, 8'hE1));
        checkEvt("fake shift", 1, mk(4'h0, 1, 0, 8'h7C));
        checkEvt("shift before bat", 2, mk(4'h1, 0, 0, 8'h12));
        checkEvt("after bat", 3, mk(4'h0, 0, 0, 8'h1C));
        logQ.delete();

        // Overflow with a stalled consumer, then drain one per cycle
        @(negedge CLOCK);
        iReady = 1'b0;
        ovfSeen = 0;
        sendSeq(64'h15_1D_24_2D_2C, 5);
        idle(4);
        checkLit("overflow pulses", ovfSeen, 1);
        checkLit("held head", oCode, 8'h15);
        @(negedge CLOCK);
        iReady = 1'b1;
        idle(3);
        checkLit("drain last valid", {oValid, oCode}, {1'b1, 8'h2D});
        idle(1);
        checkLit("drain empty", oValid, 0);
        checkLit("drain count", logQ.size(), 4);
        checkEvt("drain 0", 0, mk(4'h0, 0, 0, 8'h15));
        checkEvt("drain 3", 3, mk(4'h0, 0, 0, 8'h2D));
        logQ.delete();

        // Reset mid-sequence discards queue and pending break prefix
        @(negedge CLOCK);
        iReady = 1'b0;
        sendSeq(64'h1C_32_F0, 3);
        idle(2);
        checkLit("queued before reset", oValid, 1);
        @(negedge CLOCK);
        RST = 1'b1;
        @(negedge CLOCK);
        RST = 1'b0;
        checkLit("reset clears queue", oValid, 0);
        iReady = 1'b1;
        sendByte(8'h1C);
        idle(6);
        checkLit("post reset count", logQ.size(), 1);
        checkEvt("post reset make", 0, mk(4'h0, 0, 0, 8'h1C));

        compareEn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_keyevent_module.md
Name: ps2_keyevent_module

Overview:
- Consumes the byte stream from the PS/2 receive function module (its oTrig/oData pair) and turns scan-code-set-2 byte sequences into key events.
- Folds E0 (extended) and F0 (break) prefixes, swallows the 8-byte Pause sequence and the E0 12 fake-shift bytes, and tracks modifier/Caps Lock state.
- Buffers events in a small FIFO with a valid/ready handshake toward the application (ASCII mapper, display or UART stage).

Parameters:
- FIFO_DEPTH, 4, event buffer entries; power of two, at least 2.
- PAUSE_LEN, 7, bytes swallowed after the E1 that opens a Pause sequence.

Ports:
- CLOCK  input  1  system clock.
- RST  input  1  reset.
- iTrig  input  1  one-cycle strobe: iData holds a newly received byte.
- iData  input  8  received scan-code byte.
- oValid  output  1  FIFO head holds an event.
- iReady  input  1  consumer accepts the head; pop when oValid&&iReady.
- oCode  output  8  head event scan code (E1 for Pause).
- oExt  output  1  head event was E0/E1-prefixed.
- oBreak  output  1  head event is a release.
- oMods  output  4  {caps, alt, ctrl, shift} snapshot stored with the head event.
- oOverflow  output  1  one-cycle pulse: an event was dropped because the FIFO was full.

Interface: one clock, CLOCK; reset RST is synchronous and active-high. All outputs are registered.

Behaviour:
- Reset: decoder state IDLE, pause counter 0, modifier flags, caps, caps_held and FIFO cleared. oValid=0, oCode=0, oExt=0, oBreak=0, oMods=0, oOverflow=0. RST mid-sequence discards any partial prefix and all queued events.
- Bytes are processed only on cycles with iTrig=1. iTrig is never asserted on consecutive cycles, but no such constraint is required of the block.
- Decoder FSM:
  - IDLE:
    - F0 -> BRK.
    - E0 -> EXT.
    - E1 -> PAUSE, counter=PAUSE_LEN.
    - AA (BAT pass) -> clear all modifiers and caps, no event.
    - 00, FF, FA, EE, FE -> dropped silently.
    - Any other byte -> make event, ext=0.
  - EXT: F0 -> EXTBRK; 12 -> IDLE with no event; else make event, ext=1, then IDLE.
  - BRK: break event, ext=0, then IDLE.
  - EXTBRK: 12 -> IDLE with no event; else break event, ext=1, then IDLE.
  - PAUSE: decrement on each byte. When the counter reaches 0, emit one make event code=E1, ext=1, then IDLE. No break event is produced for Pause.
- Modifiers are updated in the same cycle as the event, and the stored oMods reflects the update (a shift make carries shift=1; a shift break carries shift=0).
  - shift = lshift(12) | rshift(59); ext=0 only.
  - ctrl = lctrl(14) | rctrl(E0 14).
  - alt = lalt(11) | ralt(E0 11).
  - caps (58): toggles on make only when caps_held=0; make sets caps_held, break clears it, so typematic repeats do not toggle.
- FIFO:
  - Push on event when count<FIFO_DEPTH, or when a pop occurs in the same cycle.
  - Otherwise the event is dropped and oOverflow pulses for 1 cycle.
  - Pop and push in the same cycle when empty: not possible, because the head is registered. A push into an empty FIFO appears as oValid=1 on the next cycle.
  - Latency: iTrig of the final byte at edge n -> oValid=1 after edge n+1.
  - Head fields are stable while oValid=1 and iReady=0.
  - Pointers wrap modulo FIFO_DEPTH; count is width clog2(FIFO_DEPTH)+1.

Decomposition:
- Shared package ps2_pkg: scan-code constants (PFX_EXT=E0, PFX_BRK=F0, PFX_PAUSE=E1, BAT_OK=AA, the LSHIFT/RSHIFT/CTRL/ALT/CAPS codes, FAKE_SHIFT=12), the FSM state encoding, and the event record layout {mods[3:0], ext, brk, code[7:0]} (14 bits).
- One sub-module: ps2_event_fifo (generic synchronous FIFO; WIDTH=14, DEPTH=FIFO_DEPTH; push/pop/full/empty).

Test Plan:
- Bytes 1C, F0 1C with iReady=1 -> two events: {1C, ext0, brk0, mods0} then {1C, ext0, brk1, mods0}.
- 12, 1C, F0 1C, F0 12 -> events carry shift=1, 1, 1, then the shift break with shift=0. E0 75 -> code 75, ext=1. E0 F0 75 -> ext=1, brk=1.
- 58, 58, 58, F0 58, 58 -> caps=1 after the first make; the repeats keep caps=1; after the break and new make, caps=0.
- Pause sequence E1 14 77 E1 F0 14 F0 77 -> exactly one event {E1, ext1, brk0}. E0 12 E0 7C -> a single event {7C, ext1}.
- iReady=0, send 5 make codes -> 4 queued, one oOverflow pulse on the 5th. Raise iReady -> the 4 events drain in order, one per cycle.
- RST asserted after F0 with 2 events queued -> oValid=0 next cycle. A following 1C yields a make event (BRK state discarded).
